// File: rtl/iseq_scheduler_pkg.sv
// iseq_sched_pkg: shared types for the instruction-sequence scheduler.
// Holds the FSM state encoding, the requester identifiers and the default
// pad word that odd-length sequences are topped up with.
package iseq_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PAD       = 3'd2,
    ST_KICK      = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_DRAIN     = 3'd5
  } sched_state_e;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_MNT  = 1'b1
  } req_id_e;

  localparam int unsigned DEFAULT_MAX_SEQ_LEN = 64;
  localparam logic [31:0] DEFAULT_NOP         = 32'h0000_0000;

  // One-hot grant vector {mnt,host} for a requester id.
  function automatic logic [1:0] req_onehot(input req_id_e id);
    return (id == REQ_MNT) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/iseq_scheduler_if.sv
// iseq_scheduler_if: bundles the host stream, the maintenance stream, the two
// instruction FIFO write ports and the dispatcher kick/busy pair.
// master = scheduler side, slave = everything around it.
interface iseq_scheduler_if;

  logic [31:0] host_instr;
  logic        host_valid;
  logic        host_last;
  logic        host_ready;

  logic [31:0] mnt_instr;
  logic        mnt_valid;
  logic        mnt_last;
  logic        mnt_urgent;
  logic        mnt_ready;

  logic        instr0_fifo_wr;
  logic [31:0] instr0_fifo_data;
  logic        instr0_fifo_full;
  logic        instr1_fifo_wr;
  logic [31:0] instr1_fifo_data;
  logic        instr1_fifo_full;

  logic        process_iseq;
  logic        dispatcher_busy;

  logic [1:0]  grant;
  logic        sched_idle;
  logic        seq_err;

  modport master (
    input  host_instr, host_valid, host_last,
    input  mnt_instr, mnt_valid, mnt_last, mnt_urgent,
    input  instr0_fifo_full, instr1_fifo_full, dispatcher_busy,
    output host_ready, mnt_ready,
    output instr0_fifo_wr, instr0_fifo_data, instr1_fifo_wr, instr1_fifo_data,
    output process_iseq, grant, sched_idle, seq_err
  );

  modport slave (
    output host_instr, host_valid, host_last,
    output mnt_instr, mnt_valid, mnt_last, mnt_urgent,
    output instr0_fifo_full, instr1_fifo_full, dispatcher_busy,
    input  host_ready, mnt_ready,
    input  instr0_fifo_wr, instr0_fifo_data, instr1_fifo_wr, instr1_fifo_data,
    input  process_iseq, grant, sched_idle, seq_err
  );

endinterface

// File: rtl/iseq_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with an urgent override for the
// maintenance requester. Purely combinational; the caller owns the pointer
// register and loads ptr_nxt_o whenever it takes the grant.
module rr_arb2
  import iseq_sched_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       urgent_i,
  input  req_id_e    ptr_i,
  output logic [1:0] grant_o,
  output req_id_e    ptr_nxt_o
);

  req_id_e winner;

  // Urgent maintenance first, then a lone requester, then the RR pointer breaks the tie.
  always_comb begin
    winner    = ptr_i;
    grant_o   = 2'b00;
    ptr_nxt_o = ptr_i;
    if (urgent_i && req_i[1]) begin
      winner = REQ_MNT;
    end else if (req_i == 2'b01) begin
      winner = REQ_HOST;
    end else if (req_i == 2'b10) begin
      winner = REQ_MNT;
    end
    if (req_i != 2'b00) begin
      grant_o   = req_onehot(winner);
      ptr_nxt_o = (winner == REQ_MNT) ? REQ_HOST : REQ_MNT;
    end
  end

endmodule

// File: rtl/iseq_scheduler.sv
// iseq_scheduler: shares the two instruction FIFOs between the host stream and
// the maintenance requester, one whole sequence at a time. Beats alternate
// between instr0 (even) and instr1 (odd); odd-length sequences get a pad word
// in instr1, then the dispatcher is kicked once and must drain before the next
// grant. Optional statistics counters are built when ISEQ_SCHED_STATS_EN is
// defined.
module iseq_scheduler
  import iseq_sched_pkg::*;
#(
  parameter int unsigned MAX_SEQ_LEN = DEFAULT_MAX_SEQ_LEN,
  parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  iseq_scheduler_if.master  bus
`ifdef ISEQ_SCHED_STATS_EN
  ,
  output logic [15:0]       host_seq_cnt,
  output logic [15:0]       mnt_seq_cnt,
  output logic [15:0]       pad_cnt
`endif
);

  localparam int unsigned       CNT_W    = $clog2(MAX_SEQ_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_SEQ_LEN - 1);

  sched_state_e     state_q, state_d;
  req_id_e          owner_q, owner_d;
  req_id_e          rr_ptr_q, rr_ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             seq_err_q, seq_err_d;

  logic [1:0]       arb_grant;
  req_id_e          arb_ptr_nxt;

  logic             owner_valid;
  logic             owner_last;
  logic [31:0]      owner_instr;
  logic             target_full;
  logic             owner_ready;
  logic             beat_acc;
  logic             seq_end;
  logic             pad_wr;

  rr_arb2 u_arb (
    .req_i     ({bus.mnt_valid, bus.host_valid}),
    .urgent_i  (bus.mnt_urgent),
    .ptr_i     (rr_ptr_q),
    .grant_o   (arb_grant),
    .ptr_nxt_o (arb_ptr_nxt)
  );

  // Select the granted requester's beat and decide whether it is taken this cycle.
  always_comb begin
    owner_valid = (owner_q == REQ_MNT) ? bus.mnt_valid : bus.host_valid;
    owner_last  = (owner_q == REQ_MNT) ? bus.mnt_last  : bus.host_last;
    owner_instr = (owner_q == REQ_MNT) ? bus.mnt_instr : bus.host_instr;
    target_full = count_q[0] ? bus.instr1_fifo_full : bus.instr0_fifo_full;
    owner_ready = (state_q == ST_LOAD) && !target_full;
    beat_acc    = owner_ready && owner_valid;
    seq_end     = beat_acc && (owner_last || (count_q == LAST_IDX));
    pad_wr      = (state_q == ST_PAD) && !bus.instr1_fifo_full;
  end

  assign bus.host_ready       = owner_ready && (owner_q == REQ_HOST);
  assign bus.mnt_ready        = owner_ready && (owner_q == REQ_MNT);
  assign bus.instr0_fifo_wr   = beat_acc && !count_q[0];
  assign bus.instr0_fifo_data = owner_instr;
  assign bus.instr1_fifo_wr   = (beat_acc && count_q[0]) || pad_wr;
  assign bus.instr1_fifo_data = (state_q == ST_PAD) ? NOP_INSTR : owner_instr;
  assign bus.process_iseq     = (state_q == ST_KICK);
  assign bus.grant            = grant_q;
  assign bus.sched_idle       = (state_q == ST_IDLE);
  assign bus.seq_err          = seq_err_q;

  // Next-state logic for the sequencing FSM and its bookkeeping registers.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    count_d   = count_q;
    seq_err_d = seq_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_grant != 2'b00) begin
          grant_d  = arb_grant;
          owner_d  = arb_grant[1] ? REQ_MNT : REQ_HOST;
          rr_ptr_d = arb_ptr_nxt;
          count_d  = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat_acc) begin
          count_d = count_q + CNT_W'(1);
          if (seq_end) begin
            if (!owner_last) begin
              seq_err_d = 1'b1;
            end
            state_d = count_q[0] ? ST_KICK : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (!bus.instr1_fifo_full) begin
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.dispatcher_busy) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.dispatcher_busy) begin
          state_d = ST_IDLE;
          count_d = '0;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_HOST;
      rr_ptr_q  <= REQ_HOST;
      grant_q   <= 2'b00;
      count_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef ISEQ_SCHED_STATS_EN
  logic [15:0] host_cnt_q, mnt_cnt_q, pad_cnt_q;
  logic        kick_entry, pad_entry;

  assign kick_entry = (state_d == ST_KICK) && (state_q != ST_KICK);
  assign pad_entry  = (state_d == ST_PAD)  && (state_q != ST_PAD);

  // Saturating counts of kicked sequences per owner and of pad insertions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_cnt_q <= 16'd0;
      mnt_cnt_q  <= 16'd0;
      pad_cnt_q  <= 16'd0;
    end else begin
      if (kick_entry && (owner_q == REQ_HOST) && (host_cnt_q != 16'hFFFF)) begin
        host_cnt_q <= host_cnt_q + 16'd1;
      end
      if (kick_entry && (owner_q == REQ_MNT) && (mnt_cnt_q != 16'hFFFF)) begin
        mnt_cnt_q <= mnt_cnt_q + 16'd1;
      end
      if (pad_entry && (pad_cnt_q != 16'hFFFF)) begin
        pad_cnt_q <= pad_cnt_q + 16'd1;
      end
    end
  end

  assign host_seq_cnt = host_cnt_q;
  assign mnt_seq_cnt  = mnt_cnt_q;
  assign pad_cnt      = pad_cnt_q;
`endif

endmodule

// File: tb/tb_iseq_scheduler.sv
// tb_iseq_scheduler: randomized bench for the instruction-sequence scheduler.
// Two sequence sources (host, maintenance), random FIFO-full back-pressure and
// a dispatcher that goes busy after each kick. A sequence-level model predicts
// arbitration, the exact FIFO word streams, pad words, kicks and seq_err.
module tb_iseq_scheduler;

  localparam logic [31:0] TB_NOP       = 32'h0BAD_F00D;
  localparam int          MAX_LEN      = 64;
  localparam int          HOST_SEQS    = 12;
  localparam int          MNT_SEQS     = 12;
  localparam int          CYCLE_BUDGET = 20000;

  logic clk;
  logic rst_n;

  iseq_scheduler_if bus();

`ifdef ISEQ_SCHED_STATS_EN
  logic [15:0] host_seq_cnt, mnt_seq_cnt, pad_cnt;
`endif

  iseq_scheduler #(
    .MAX_SEQ_LEN (MAX_LEN),
    .NOP_INSTR   (TB_NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef ISEQ_SCHED_STATS_EN
    ,
    .host_seq_cnt (host_seq_cnt),
    .mnt_seq_cnt  (mnt_seq_cnt),
    .pad_cnt      (pad_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errCount;
  int          checkCount;

  int          srcTodo[2];
  int          srcIssued[2];
  int          srcLen[2];
  int          srcIdx[2];
  bit          srcActive[2];
  bit          srcHasLast[2];
  bit          srcUrgent[2];
  bit          srcAcc[2];
  bit          drvValid[2];
  logic [14:0] srcSalt[2];

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  bit          modelIdle, modelIdleNext, awaitDrain, sawBusy, kickedThisSeq;
  bit          prevKick, grantPending, kickToDispatcher, expErr;
  bit          drvFull0, drvFull1;
  int          modelPtr, modelOwner, busyLeft, fullBurst;
  logic [1:0]  expGrant;
  int          expKicks[2];
  int          expPads;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] beatWord(input int s, input logic [14:0] salt, input int idx);
    return {1'b1, salt, 8'(s), 8'(idx)};
  endfunction

  // Pick the next sequence for a source: a few fixed openers, then random lengths.
  task automatic startSeq(input int s);
    int n;
    n = srcIssued[s];
    srcHasLast[s] = 1'b1;
    srcUrgent[s]  = 1'b0;
    if (s == 0) begin
      if (n == 0)      srcLen[s] = 4;
      else if (n == 1) srcLen[s] = 3;
      else if (n == 4) begin
        srcLen[s]     = MAX_LEN;
        srcHasLast[s] = 1'b0;
      end
      else srcLen[s] = $urandom_range(1, 9);
    end else begin
      if (n == 0) srcLen[s] = 2;
      else if (n == 1) begin
        srcLen[s]    = 5;
        srcUrgent[s] = 1'b1;
      end else begin
        srcLen[s]    = $urandom_range(1, 7);
        srcUrgent[s] = ($urandom_range(0, 3) == 0);
      end
    end
    srcSalt[s]   = 15'($urandom);
    srcIdx[s]    = 0;
    srcActive[s] = 1'b1;
    srcIssued[s]++;
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus();
    for (int s = 0; s < 2; s++) begin
      if (srcAcc[s]) begin
        srcIdx[s]++;
        if (srcIdx[s] == srcLen[s]) begin
          srcActive[s] = 1'b0;
          srcTodo[s]--;
        end
      end
      srcAcc[s] = 1'b0;
      if (!srcActive[s] && srcTodo[s] > 0 && (srcIssued[s] < 2 || $urandom_range(0, 2) == 0))
        startSeq(s);
      drvValid[s] = srcActive[s] && (srcIdx[s] == 0 || $urandom_range(0, 5) != 0);
    end
    bus.host_valid = drvValid[0];
    bus.host_instr = srcActive[0] ? beatWord(0, srcSalt[0], srcIdx[0]) : 32'h0;
    bus.host_last  = srcActive[0] && srcHasLast[0] && (srcIdx[0] == srcLen[0] - 1);
    bus.mnt_valid  = drvValid[1];
    bus.mnt_instr  = srcActive[1] ? beatWord(1, srcSalt[1], srcIdx[1]) : 32'h0;
    bus.mnt_last   = srcActive[1] && srcHasLast[1] && (srcIdx[1] == srcLen[1] - 1);
    bus.mnt_urgent = srcActive[1] && srcUrgent[1];

    if (fullBurst == 0 && $urandom_range(0, 19) == 0) fullBurst = 5;
    drvFull0 = (fullBurst > 0) || ($urandom_range(0, 7) == 0);
    if (fullBurst > 0) fullBurst--;
    drvFull1 = ($urandom_range(0, 7) == 0);
    bus.instr0_fifo_full = drvFull0;
    bus.instr1_fifo_full = drvFull1;

    if (kickToDispatcher) begin
      busyLeft         = $urandom_range(1, 4);
      kickToDispatcher = 1'b0;
    end
    if (busyLeft > 0) begin
      bus.dispatcher_busy = 1'b1;
      busyLeft--;
    end else begin
      bus.dispatcher_busy = 1'b0;
    end
  endtask

  // Sample outputs on the falling edge and compare them with the sequence model.
  task automatic sampleCycle();
    logic [1:0] rdy;
    int         w;
    rdy = {bus.mnt_ready, bus.host_ready};
    if (modelIdleNext) begin
      modelIdle     = 1'b1;
      modelIdleNext = 1'b0;
      awaitDrain    = 1'b0;
      sawBusy       = 1'b0;
      kickedThisSeq = 1'b0;
      modelOwner    = -1;
    end
    checkOutput("schedIdle", bus.sched_idle, modelIdle);
    if (grantPending) begin
      checkOutput("grant", bus.grant, expGrant);
      grantPending = 1'b0;
    end
    if (modelIdle) begin
      checkOutput("idleReady", rdy, 2'b00);
      checkOutput("idleKick", bus.process_iseq, 1'b0);
    end else begin
      checkOutput("nonOwnerReady", rdy[1 - modelOwner], 1'b0);
    end
    if (prevKick) checkOutput("kickPulse", bus.process_iseq, 1'b0);
    prevKick = bus.process_iseq;

    if (bus.instr0_fifo_wr) begin
      checkOutput("wr0WhileFull", drvFull0, 1'b0);
      if (exp0.size() > 0) checkOutput("wr0Data", bus.instr0_fifo_data, exp0.pop_front());
      else checkOutput("wr0Expected", 32'(exp0.size()), 1);
    end
    if (bus.instr1_fifo_wr) begin
      checkOutput("wr1WhileFull", drvFull1, 1'b0);
      if (exp1.size() > 0) checkOutput("wr1Data", bus.instr1_fifo_data, exp1.pop_front());
      else checkOutput("wr1Expected", 32'(exp1.size()), 1);
    end

    srcAcc[0] = drvValid[0] && bus.host_ready;
    srcAcc[1] = drvValid[1] && bus.mnt_ready;

    if (bus.process_iseq && !modelIdle) begin
      checkOutput("kickOnce", kickedThisSeq, 1'b0);
      checkOutput("kickLeft0", 32'(exp0.size()), 0);
      checkOutput("kickLeft1", 32'(exp1.size()), 0);
      checkOutput("seqErr", bus.seq_err, expErr);
      kickedThisSeq    = 1'b1;
      awaitDrain       = 1'b1;
      kickToDispatcher = 1'b1;
    end
    if (awaitDrain) begin
      if (sawBusy && !bus.dispatcher_busy) modelIdleNext = 1'b1;
      else if (bus.dispatcher_busy) sawBusy = 1'b1;
    end

    if (modelIdle && (drvValid[0] || drvValid[1])) begin
      if (drvValid[1] && srcUrgent[1])      w = 1;
      else if (drvValid[0] && !drvValid[1]) w = 0;
      else if (drvValid[1] && !drvValid[0]) w = 1;
      else                                  w = modelPtr;
      modelPtr     = 1 - w;
      modelOwner   = w;
      expGrant     = (w == 1) ? 2'b10 : 2'b01;
      grantPending = 1'b1;
      modelIdle    = 1'b0;
      for (int i = 0; i < srcLen[w]; i++) begin
        if (i % 2 == 0) exp0.push_back(beatWord(w, srcSalt[w], i));
        else            exp1.push_back(beatWord(w, srcSalt[w], i));
      end
      if (srcLen[w] % 2 == 1) begin
        exp1.push_back(TB_NOP);
        expPads++;
      end
      if (!srcHasLast[w]) expErr = 1'b1;
      expKicks[w]++;
    end
  endtask

  function automatic bit allDone();
    return (srcTodo[0] == 0) && (srcTodo[1] == 0) && !srcActive[0] && !srcActive[1] &&
           modelIdle && (exp0.size() == 0) && (exp1.size() == 0) && (busyLeft == 0);
  endfunction

  initial begin
    bit found;
    errCount = 0;
    checkCount = 0;
    srcTodo[0] = HOST_SEQS;
    srcTodo[1] = MNT_SEQS;
    for (int s = 0; s < 2; s++) begin
      srcIssued[s] = 0; srcLen[s] = 0; srcIdx[s] = 0; srcActive[s] = 0;
      srcHasLast[s] = 0; srcUrgent[s] = 0; srcAcc[s] = 0; drvValid[s] = 0;
      srcSalt[s] = '0; expKicks[s] = 0;
    end
    modelIdle = 1; modelIdleNext = 0; awaitDrain = 0; sawBusy = 0; kickedThisSeq = 0;
    prevKick = 0; grantPending = 0; kickToDispatcher = 0; expErr = 0;
    drvFull0 = 0; drvFull1 = 0;
    modelPtr = 0; modelOwner = -1; busyLeft = 0; fullBurst = 0; expGrant = 2'b00; expPads = 0;

    rst_n = 1'b0;
    bus.host_instr = '0; bus.host_valid = 0; bus.host_last = 0;
    bus.mnt_instr = '0; bus.mnt_valid = 0; bus.mnt_last = 0; bus.mnt_urgent = 0;
    bus.instr0_fifo_full = 0; bus.instr1_fifo_full = 0; bus.dispatcher_busy = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstGrant", bus.grant, 2'b00);
    checkOutput("rstIdle", bus.sched_idle, 1'b1);
    checkOutput("rstSeqErr", bus.seq_err, 1'b0);
    checkOutput("rstReady", {bus.mnt_ready, bus.host_ready}, 2'b00);
    checkOutput("rstKick", bus.process_iseq, 1'b0);
    checkOutput("rstWr", {bus.instr1_fifo_wr, bus.instr0_fifo_wr}, 2'b00);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < CYCLE_BUDGET && !allDone(); cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus();
      @(negedge clk);
      sampleCycle();
    end
    checkOutput("allSeqDone", 32'(allDone()), 1);

`ifdef ISEQ_SCHED_STATS_EN
    checkOutput("hostSeqCnt", host_seq_cnt, 16'(expKicks[0]));
    checkOutput("mntSeqCnt", mnt_seq_cnt, 16'(expKicks[1]));
    checkOutput("padCnt", pad_cnt, 16'(expPads));
`endif

    // Start a host sequence and pull reset while it is loading.
    @(posedge clk);
    #1;
    bus.host_valid = 1'b1; bus.host_instr = 32'h8123_4567; bus.host_last = 1'b0;
    bus.mnt_valid = 1'b0; bus.mnt_urgent = 1'b0; bus.mnt_last = 1'b0;
    bus.instr0_fifo_full = 1'b0; bus.instr1_fifo_full = 1'b0; bus.dispatcher_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = (bus.grant == 2'b01);
    end
    checkOutput("preRstGrant", 32'(found), 1);
    checkOutput("preRstReady", bus.host_ready, 1'b1);
    checkOutput("preRstSeqErr", bus.seq_err, expErr);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", bus.host_ready, 1'b0);
    checkOutput("midRstGrant", bus.grant, 2'b00);
    checkOutput("midRstIdle", bus.sched_idle, 1'b1);
    checkOutput("midRstSeqErr", bus.seq_err, 1'b0);
    checkOutput("midRstWr0", bus.instr0_fifo_wr, 1'b0);
`ifdef ISEQ_SCHED_STATS_EN
    checkOutput("midRstPadCnt", pad_cnt, 16'd0);
`endif
    bus.host_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
